// File: rtl/fpu_add_sched.sv
// Round-robin scheduler sharing one fixed-latency FP adder between two requesters.
// Issue is credit-gated against per-requester result FIFOs so writebacks never overflow.
module fpu_add_sched #(
  parameter int LAT   = 4,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_sub,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_sub,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic [31:0] fpu_out,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic        busy
);

  localparam int DATA_W = 32;
  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = PW + 1;
  localparam int SW     = CW + 1;

  logic [1:0]        req_v, rsp_rdy, elig, gnt, inc, dec, pop;
  logic [CW-1:0]     cnt  [2];
  logic [CW-1:0]     infl [2];
  logic [PW-1:0]     wr_ptr [2];
  logic [PW-1:0]     rd_ptr [2];
  logic [DATA_W-1:0] mem [2][DEPTH];
  logic              lg, xfer, xid, wb, wid, sub_sel;
  logic [DATA_W-1:0] a_sel, b_sel;
  logic [LAT:0]      tag_vld_p, tag_id_p;

  always_comb begin
    req_v   = {req1_valid, req0_valid};
    rsp_rdy = {rsp1_ready, rsp0_ready};
    elig    = 2'b00;
    pop     = 2'b00;
    for (int i = 0; i < 2; i++) begin
      elig[i] = req_v[i] && ((SW'(cnt[i]) + SW'(infl[i])) < SW'(DEPTH));
      pop[i]  = (cnt[i] != '0) && rsp_rdy[i];
    end
    // Grants are held off entirely while reset is asserted.
    gnt = 2'b00;
    if (rst_n) begin
      if (elig == 2'b11) gnt = lg ? 2'b01 : 2'b10;
      else               gnt = elig;
    end
    xfer    = |gnt;
    xid     = gnt[1];
    a_sel   = xid ? req1_a   : req0_a;
    b_sel   = xid ? req1_b   : req0_b;
    sub_sel = xid ? req1_sub : req0_sub;
    wb      = tag_vld_p[LAT];
    wid     = tag_id_p[LAT];
    inc     = {xfer & xid, xfer & ~xid};
    dec     = {wb & wid, wb & ~wid};
  end

  // Stage p0: operand issue; tags then ride alongside the adder to index LAT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lg        <= 1'b1;
      fpu_a     <= '0;
      fpu_b     <= '0;
      tag_vld_p <= '0;
      tag_id_p  <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt[i]    <= '0;
        infl[i]   <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      if (xfer) begin
        lg    <= xid;
        fpu_a <= a_sel;
        fpu_b <= {b_sel[DATA_W-1] ^ sub_sel, b_sel[DATA_W-2:0]};
      end
      tag_vld_p <= {tag_vld_p[LAT-1:0], xfer};
      tag_id_p  <= {tag_id_p[LAT-1:0], xid};
      for (int i = 0; i < 2; i++) begin
        infl[i]   <= infl[i] + CW'(inc[i]) - CW'(dec[i]);
        cnt[i]    <= cnt[i] + CW'(dec[i]) - CW'(pop[i]);
        wr_ptr[i] <= wr_ptr[i] + PW'(dec[i]);
        rd_ptr[i] <= rd_ptr[i] + PW'(pop[i]);
      end
    end
  end

  // Stage LAT+1: writeback into the owning requester's FIFO.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (dec[i]) mem[i][wr_ptr[i]] <= fpu_out;
    end
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign rsp0_valid = (cnt[0] != '0);
  assign rsp1_valid = (cnt[1] != '0);
  assign rsp0_data  = rsp0_valid ? mem[0][rd_ptr[0]] : '0;
  assign rsp1_data  = rsp1_valid ? mem[1][rd_ptr[1]] : '0;
  assign busy       = (|tag_vld_p) | rsp0_valid | rsp1_valid;

endmodule

// File: tb/tb_fpu_add_sched.sv
// Directed bench for fpu_add_sched with a behavioural fixed-latency adder model.
module tb_fpu_add_sched;

  localparam int LAT   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid, req0_ready, req0_sub, req1_valid, req1_ready, req1_sub;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [31:0] fpu_a, fpu_b, fpu_out;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready, busy;
  logic [31:0] rsp0_data, rsp1_data;

  int errors = 0;
  int checks = 0;
  int i0, i1, t0, t1;
  int both_rdy = 0;
  int ovf = 0;
  logic [31:0] fv [0:12];
  logic [31:0] r0q [$];
  logic [31:0] r1q [$];
  int gq [$];
  logic [31:0] apipe [LAT];

  always #5 clk = ~clk;

  fpu_add_sched #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_out(fpu_out),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .busy(busy)
  );

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) d = {f[31], 63'd0};
    else d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Exact results only; anything needing rounding becomes a NaN so it cannot match.
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    if (d[28:0] != 29'd0 || d[62:52] < 11'd897 || d[62:52] > 11'd1150) return 32'h7FC00000;
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  // Adder: samples operands at an edge, result stable LAT edges after the issue edge.
  always @(posedge clk) begin
    apipe[0] <= r2f(f2r(fpu_a) + f2r(fpu_b));
    for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
  end
  assign fpu_out = apipe[LAT-1];

  always @(negedge clk) begin
    if (rst_n) begin
      if (req0_ready && req1_ready) both_rdy++;
      if (req0_valid && req0_ready) gq.push_back(0);
      if (req1_valid && req1_ready) gq.push_back(1);
      if (rsp0_valid && rsp0_ready) r0q.push_back(rsp0_data);
      if (rsp1_valid && rsp1_ready) r1q.push_back(rsp1_data);
      if (dut.wb && int'(dut.cnt[dut.wid]) >= DEPTH) ovf++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int idx(input int x);
    return (x > 12) ? 12 : x;
  endfunction

  task automatic drive();
    req0_valid = (i0 < t0);
    req0_a = fv[idx(i0 + 1)];
    req0_b = fv[1];
    req0_sub = 1'b0;
    req1_valid = (i1 < t1);
    req1_a = fv[idx(i1 + 2)];
    req1_b = fv[1];
    req1_sub = 1'b1;
  endtask

  task automatic tick();
    bit x0, x1;
    @(negedge clk);
    x0 = req0_valid && req0_ready;
    x1 = req1_valid && req1_ready;
    @(posedge clk); #1;
    if (x0) i0++;
    if (x1) i1++;
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    r0q.delete(); r1q.delete(); gq.delete();
    i0 = 0; i1 = 0; t0 = 0; t1 = 0;
  endtask

  task automatic wait_rsp(input bit which, input int maxc, input string tag);
    int n = 0;
    while (((which ? rsp1_valid : rsp0_valid) == 1'b0) && n < maxc) begin
      @(posedge clk); #1; n++;
    end
    check(tag, 32'(which ? rsp1_valid : rsp0_valid), 32'd1);
  endtask

  task automatic wait_idle(input int maxc, input string tag);
    int n = 0;
    while (busy && n < maxc) begin
      @(posedge clk); #1; n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic run_until_issued(input int maxc, input string tag);
    int n = 0;
    while ((i0 < t0 || i1 < t1) && n < maxc) begin
      tick(); n++;
    end
    check(tag, 32'(i0 + i1), 32'(t0 + t1));
  endtask

  task automatic check_q0(input int n, input int base, input string tag);
    logic [31:0] got;
    check({tag, "_n"}, 32'(r0q.size()), 32'(n));
    for (int k = 0; k < n; k++) begin
      got = (r0q.size() > 0) ? r0q.pop_front() : 32'hDEADBEEF;
      check($sformatf("%s_%0d", tag, k), got, fv[idx(base + k)]);
    end
  endtask

  task automatic check_q1(input int n, input int base, input string tag);
    logic [31:0] got;
    check({tag, "_n"}, 32'(r1q.size()), 32'(n));
    for (int k = 0; k < n; k++) begin
      got = (r1q.size() > 0) ? r1q.pop_front() : 32'hDEADBEEF;
      check($sformatf("%s_%0d", tag, k), got, fv[idx(base + k)]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int spur, n;
    fv[0] = 32'h00000000; fv[1] = 32'h3F800000; fv[2] = 32'h40000000; fv[3] = 32'h40400000;
    fv[4] = 32'h40800000; fv[5] = 32'h40A00000; fv[6] = 32'h40C00000; fv[7] = 32'h40E00000;
    fv[8] = 32'h41000000; fv[9] = 32'h41100000; fv[10] = 32'h41200000; fv[11] = 32'h41300000;
    fv[12] = 32'h41400000;
    req0_valid = 1'b1; req0_a = fv[1]; req0_b = fv[1]; req0_sub = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    i0 = 0; i1 = 0; t0 = 0; t1 = 0;

    // Reset values, with a request pending to show ready is held low.
    repeat (2) @(posedge clk);
    #1;
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_fpu_a", fpu_a, 32'd0);
    check("rst_fpu_b", fpu_b, 32'd0);
    check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("rst_rsp0_data", rsp0_data, 32'd0);
    check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    req0_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Add: 1.0 + 2.0, result visible after the fifth edge.
    req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40000000; req0_sub = 1'b0;
    #1 check("add_ready", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    check("add_fpu_a", fpu_a, 32'h3F800000);
    check("add_fpu_b", fpu_b, 32'h40000000);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("add_vld_e%0d", k), 32'(rsp0_valid), (k == 5) ? 32'd1 : 32'd0);
    end
    check("add_data", rsp0_data, 32'h40400000);
    rsp0_ready = 1'b1;
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    check("add_popped", 32'(rsp0_valid), 32'd0);

    // Subtract: 3.0 - 1.0 on requester 1.
    req1_valid = 1'b1; req1_a = 32'h40400000; req1_b = 32'h3F800000; req1_sub = 1'b1;
    #1 check("sub_ready", 32'(req1_ready), 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    check("sub_fpu_b", fpu_b, 32'hBF800000);
    wait_rsp(1'b1, 10, "sub_vld");
    check("sub_data", rsp1_data, 32'h40000000);
    rsp1_ready = 1'b1;
    @(posedge clk); #1;
    rsp1_ready = 1'b0;

    // Round-robin with both streams valid and both consumers ready.
    do_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    t0 = 4; t1 = 4;
    drive();
    run_until_issued(40, "rr_issued");
    wait_idle(30, "rr_idle");
    check("rr_grants_n", 32'(gq.size()), 32'd8);
    for (int k = 0; k < 8; k++)
      check($sformatf("rr_grant_%0d", k), (gq.size() > k) ? 32'(gq[k]) : 32'hFFFFFFFF, 32'(k % 2));
    check("rr_excl", 32'(both_rdy), 32'd0);
    check_q0(4, 2, "rr_r0");
    check_q1(4, 1, "rr_r1");

    // Backpressure: requester 0's consumer stalled.
    do_reset();
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    t0 = 8; t1 = 0;
    drive();
    repeat (12) tick();
    check("bp_acc4", 32'(i0), 32'd4);
    #1 check("bp_rdy_low", 32'(req0_ready), 32'd0);
    t1 = 4;
    drive();
    repeat (4) tick();
    check("bp_req1_rate", 32'(i1), 32'd4);
    check("bp_still4", 32'(i0), 32'd4);
    rsp0_ready = 1'b1;
    #1 check("bp_rdy_popcyc", 32'(req0_ready), 32'd0);
    tick();
    #1 check("bp_rdy_back", 32'(req0_ready), 32'd1);
    run_until_issued(60, "bp_issued");
    wait_idle(40, "bp_idle");
    check_q0(8, 2, "bp_r0");
    check_q1(4, 1, "bp_r1");
    check("bp_excl", 32'(both_rdy), 32'd0);

    // Reset two cycles after three issues.
    do_reset();
    t0 = 3;
    drive();
    n = 0;
    while (i0 < 3 && n < 10) begin tick(); n++; end
    tick(); tick();
    rst_n = 1'b0;
    req0_valid = 1'b1;
    #1;
    check("mr_fpu_a", fpu_a, 32'd0);
    check("mr_fpu_b", fpu_b, 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_ready", 32'(req0_ready), 32'd0);
    check("mr_rsp0_valid", 32'(rsp0_valid), 32'd0);
    req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    spur = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (rsp0_valid || rsp1_valid || busy) spur++;
    end
    check("mr_no_spur", 32'(spur), 32'd0);
    req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h3F800000; req0_sub = 1'b0;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_rsp(1'b0, 10, "mr_new_vld");
    check("mr_new_data", rsp0_data, 32'h40000000);

    // Ten sequential ops through a 4-deep FIFO with a concurrent pop.
    do_reset();
    rsp0_ready = 1'b1;
    t0 = 10;
    drive();
    run_until_issued(80, "wrap_issued");
    wait_idle(30, "wrap_idle");
    check_q0(10, 2, "wrap_r0");
    check("no_overflow", 32'(ovf), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_add_sched.md
# fpu_add_sched

Two-requester scheduler that shares one 32-bit single-precision adder pipeline. The adder has a fixed latency, no valid signal and no stall. The block arbitrates round-robin between two operand streams and turns subtract requests into adds by flipping the sign of b. It tracks each issued operation through the adder with a tag pipeline and returns each result, in order, through a per-requester result FIFO. It sits between the client datapaths and the adder instance. Issue is credit-gated so that no result is ever dropped.

## Interface
- LAT, 4: adder latency in clock edges, from operands sampled to result stable on `fpu_out`.
- DEPTH, 4: entries per result FIFO; a power of two, at least 2.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req0_valid` / `req1_valid` in 1: operation request.
- `req0_ready` / `req1_ready` out 1: grant; a transfer happens when valid and ready are both high at a rising edge.
- `req0_a`, `req0_b` / `req1_a`, `req1_b` in 32: IEEE-754 operands.
- `req0_sub` / `req1_sub` in 1: 1 selects a−b, 0 selects a+b.
- `fpu_a`, `fpu_b` out 32: registered operands to the adder.
- `fpu_out` in 32: adder result.
- `rsp0_valid` / `rsp1_valid` out 1: result FIFO not empty.
- `rsp0_ready` / `rsp1_ready` in 1: a pop happens when valid and ready are both high.
- `rsp0_data` / `rsp1_data` out 32: FIFO head, first-word fall-through.
- `busy` out 1: any tag in flight or any FIFO not empty.

## Operation
- **Credit rule.** Requester i is eligible when `reqi_valid` is high and `cnt_i + infl_i < DEPTH`.
  - `cnt_i` is the FIFO occupancy.
  - `infl_i` is the number of issued operations not yet written to the FIFO.
  - Both are registered, so a pop in cycle N frees credit only from cycle N+1.
- **Arbitration.** Round-robin with a last-grant pointer `lg`.
  - Only one requester eligible: grant it.
  - Both eligible: grant the one that is not `lg`.
  - `lg` updates to the winner on every transfer.
  - After reset `lg` = 1, so requester 0 wins the first tie.
- **Ready signals.** `reqi_ready` is combinational and equals grant_i; at most one is high per cycle.
- **Issue.** On a transfer:
  - `fpu_a` <= a.
  - `fpu_b` <= {b[31]^sub, b[30:0]}.
  - `tag[0]` <= {1, id}.
  - Increment `infl_id`.
  - With no transfer, `fpu_a` and `fpu_b` hold their values and `tag[0]` valid <= 0.
- **Tag pipeline.** LAT+1 entries, indices 0..LAT; each entry is {valid, id}. `tag[k]` <= `tag[k-1]` every edge.
- **Writeback.** When `tag[LAT]` is valid:
  - Write `fpu_out` into FIFO `id` at the next edge.
  - Decrement `infl_id`.
  - Credit guarantees the FIFO is never full at that point. The bench asserts this.
- **Result FIFO.** Circular buffer with pointer width log2(DEPTH) plus a separate count.
  - Simultaneous write and pop keeps `cnt` unchanged.
  - Pointers wrap modulo DEPTH.
- **Ordering.** Results return in acceptance order per requester. There is no ordering between requesters.
- **Reset values.**
  - `fpu_a`, `fpu_b`, all tags, counts and pointers are 0; `lg` = 1.
  - `req*_ready` = 0 while `rst_n` is low.
  - `rsp*_valid` = 0, `rsp*_data` = 0, `busy` = 0.
- **Reset mid-operation.** In-flight tags are cleared. Results the un-reset adder later produces are ignored because their tags are invalid. FIFO contents are lost.

## Timing
- A transfer at edge N gives:
  - Operands on `fpu_a`/`fpu_b` in cycle N+1.
  - The adder samples them at edge N+1.
  - `tag[LAT]` valid and `fpu_out` stable after edge N+LAT.
  - FIFO write at edge N+LAT+1.
  - `rspi_valid` high after edge N+LAT+1: 5 edges for LAT=4.
- Throughput is one issue per cycle in total; a single requester with space can issue every cycle.
- Sustained throughput per requester with an always-ready consumer: full rate needs DEPTH ≥ LAT+2. With the defaults, a lone requester stalls after 4 outstanding until the first writeback/pop frees credit.

## Test plan
- **Add.** req0 a=0x3F800000, b=0x40000000, sub=0, accepted at edge N → `rsp0_data`=0x40400000 (3.0), `rsp0_valid` rising after edge N+5.
- **Subtract.** req1 a=0x40400000, b=0x3F800000, sub=1 → `fpu_b`=0xBF800000 in cycle N+1; `rsp1_data`=0x40000000 (2.0).
- **Round-robin.** Both valid continuously and both rsp_ready high → grants out of reset go 0,1,0,1…; ready is never high on both in the same cycle; each stream's results arrive in order.
- **Backpressure.** `rsp0_ready`=0 with req0 streaming 8 operations → exactly 4 accepted, then `req0_ready` stays low; req1 keeps issuing at full rate.
  - Raise `rsp0_ready` → 4 results pop in order.
  - `req0_ready` returns one cycle after the first pop.
  - No FIFO overflow assertion fires.
- **Reset mid-flight.** Drop `rst_n` 2 cycles after 3 issues → all outputs reset immediately; after release, no `rsp*_valid` appears without a new request, and a new 1.0+1.0 returns 0x40000000.
- **Wrap.** With a concurrent pop each cycle, run 10 sequential req0 ops → all 10 results correct and in order across pointer wrap.
